// File: rtl/pon_uart_pkg.sv
// Shared UART definitions: receiver state encoding, byte width and baud divisor helper.
package pon_uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/pon_byte_fifo.sv
// Show-ahead byte FIFO with a registered head. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter. Shared by the serial RX and TX paths.
module pon_byte_fifo
  import pon_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic [BYTE_W-1:0] pushData,
  input  logic              pop,
  output logic [BYTE_W-1:0] popData,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [BYTE_W-1:0] r_head;

  logic              w_do_push;
  logic              w_do_pop;
  logic [AW:0]       w_rptr_nxt;
  logic [AW:0]       w_count;
  logic [AW:0]       w_remain;
  logic [AW:0]       w_count_nxt;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees a slot.
  assign w_do_pop    = pop && !empty;
  assign w_do_push   = push && (!full || w_do_pop);
  assign w_rptr_nxt  = r_rptr + (AW+1)'(w_do_pop);
  assign w_count     = r_wptr - r_rptr;
  assign w_remain    = w_count - (AW+1)'(w_do_pop);
  assign w_count_nxt = w_remain + (AW+1)'(w_do_push);

  assign popData = r_head;

  // Pointer and head register update; the head holds its last value while the FIFO is empty.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_head <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      r_rptr <= w_rptr_nxt;
      if (w_do_push && (w_remain == '0)) begin
        r_head <= pushData;
      end else if (w_count_nxt != '0) begin
        r_head <= r_mem[w_rptr_nxt[AW-1:0]];
      end
    end
  end

  // Storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; entries are only read after being written, so reset buys nothing.
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// Keyboard-path UART receive front end: 2-flop synchroniser, mid-bit sampling frame decoder
// and a small byte FIFO presented as a valid/ready stream.
// Define UART_RX_PARITY_EN to decode 8E1 frames; otherwise frames are 8N1.
module uart_rx_frontend
  import pon_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_SERIAL_RX,
  output logic [BYTE_W-1:0] rxData,
  output logic              rxValid,
  input  logic              rxReady,
  output logic              rxFrameErr,
  output logic              rxOverflow,
  output logic              rxBusy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_line_d;
  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_nxt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic              r_frame_err;
  logic              w_ferr_nxt;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_fall;
  logic              w_par_ok;

`ifdef UART_RX_PARITY_EN
  logic              r_par;
  logic              w_par_nxt;
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign w_par_ok = ~(^r_shift ^ r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_fall     = r_line_d & ~r_sync2;
  assign w_pop      = rxReady & ~w_empty;
  assign rxValid    = ~w_empty;
  assign rxBusy     = (r_state != RX_IDLE);
  assign rxFrameErr = r_frame_err;
  assign rxOverflow = r_overflow;

  // Bring the asynchronous line into the clock domain; presets model an idle (high) line.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_line_d <= 1'b1;
    end else begin
      r_sync1  <= IN_SERIAL_RX;
      r_sync2  <= r_sync1;
      r_line_d <= r_sync2;
    end
  end

  // Frame decoder next-state logic: start qualification, mid-bit sampling, stop/parity check.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          // A start bit that is high again by its midpoint was a glitch.
          w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[BYTE_W-1:1]};
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = RX_PARITY;
`else
            w_state_nxt = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = r_sync2;
          w_state_nxt = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (r_sync2 && w_par_ok) w_push     = 1'b1;
          else                     w_ferr_nxt = 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  // Frame decoder state register and registered error/overflow pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_ferr_nxt;
      // A good byte is lost only when the FIFO is full and nothing leaves this cycle.
      r_overflow  <= w_push & w_full & ~w_pop;
`ifdef UART_RX_PARITY_EN
      r_par       <= w_par_nxt;
`endif
    end
  end

  pon_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (w_push),
    .pushData (r_shift),
    .pop      (w_pop),
    .popData  (rxData),
    .full     (w_full),
    .empty    (w_empty)
  );

endmodule
